// File: rtl/regfile_writeback_queue_pkg.sv
// Shared types for the register-file writeback queue: word/register index types
// and the queued entry layout.
package regfile_writeback_queue_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef struct packed {
    logic     v;
    regbits_t sel;
    word_t    dat;
  } wb_entry_t;

  // Register 0 is hardwired, so writes to it are never worth queueing.
  function automatic logic sel_live(regbits_t s);
    return s != '0;
  endfunction

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Bundle of request, write-port and bypass signals around the writeback queue.
// master = producers/readers driving requests and lookups; slave = the queue.
interface regfile_writeback_queue_if #(parameter int DEPTH = 4);
  import regfile_writeback_queue_pkg::*;

  logic                     alu_valid;
  logic                     alu_ready;
  regbits_t                 alu_sel;
  word_t                    alu_dat;
  logic                     mem_valid;
  logic                     mem_ready;
  regbits_t                 mem_sel;
  word_t                    mem_dat;
  logic                     wb_en;
  logic                     rf_WEN;
  regbits_t                 rf_wsel;
  word_t                    rf_wdat;
  regbits_t                 byp_sel1;
  logic                     byp_hit1;
  word_t                    byp_dat1;
  regbits_t                 byp_sel2;
  logic                     byp_hit2;
  word_t                    byp_dat2;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output alu_valid, alu_sel, alu_dat,
    output mem_valid, mem_sel, mem_dat,
    output wb_en, byp_sel1, byp_sel2,
    input  alu_ready, mem_ready,
    input  rf_WEN, rf_wsel, rf_wdat,
    input  byp_hit1, byp_dat1, byp_hit2, byp_dat2,
    input  count
  );

  modport slave (
    input  alu_valid, alu_sel, alu_dat,
    input  mem_valid, mem_sel, mem_dat,
    input  wb_en, byp_sel1, byp_sel2,
    output alu_ready, mem_ready,
    output rf_WEN, rf_wsel, rf_wdat,
    output byp_hit1, byp_dat1, byp_hit2, byp_dat2,
    output count
  );

endinterface

// File: rtl/regfile_writeback_queue_bypass.sv
// Youngest-match lookup over the queued entries for one operand bypass port.
module wbq_bypass_match
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t        entries_i [DEPTH],
  input  logic [PTR_W-1:0] rd_ptr_i,
  input  regbits_t         sel_i,
  output logic             hit_o,
  output word_t            dat_o
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest starting at the head so the last match wins.
  always_comb begin
    hit_o = 1'b0;
    dat_o = '0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_i + PTR_W'(i);
      if (entries_i[idx].v && sel_live(sel_i) && (entries_i[idx].sel == sel_i)) begin
        hit_o = 1'b1;
        dat_o = entries_i[idx].dat;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue feeding the register file write port, with
// mem-over-ALU request arbitration and two bypass lookup ports.
module regfile_writeback_queue
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                      CLK,
  input  logic                      nRST,
  regfile_writeback_queue_if.slave  bus
);

  wb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic      not_full;
  logic      mem_acc;
  logic      alu_acc;
  logic      push;
  logic      pop;
  wb_entry_t push_entry;
  wb_entry_t head;

  // Arbitration, push/pop decisions and next pointer/count values.
  always_comb begin
    not_full   = (count_q < CNT_W'(DEPTH));
    mem_acc    = bus.mem_valid & not_full;
    alu_acc    = bus.alu_valid & not_full & ~bus.mem_valid;
    push_entry = '{v: 1'b1, sel: bus.alu_sel, dat: bus.alu_dat};
    if (bus.mem_valid) begin
      push_entry = '{v: 1'b1, sel: bus.mem_sel, dat: bus.mem_dat};
    end
    push = (mem_acc & sel_live(bus.mem_sel)) | (alu_acc & sel_live(bus.alu_sel));
    pop  = (count_q != '0) & bus.wb_en;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    head = entries_q[rd_ptr_q];
  end

  // Queue storage, pointers and occupancy; a full queue never pushes, so
  // the write slot never collides with the draining head.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop) begin
        entries_q[rd_ptr_q].v <= 1'b0;
      end
      if (push) begin
        entries_q[wr_ptr_q] <= push_entry;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.mem_ready = not_full;
  assign bus.alu_ready = not_full & ~bus.mem_valid;
  assign bus.rf_WEN    = pop;
  assign bus.rf_wsel   = (count_q != '0) ? head.sel : '0;
  assign bus.rf_wdat   = (count_q != '0) ? head.dat : '0;
  assign bus.count     = count_q;

  wbq_bypass_match #(.DEPTH(DEPTH)) u_byp1 (
    .entries_i (entries_q),
    .rd_ptr_i  (rd_ptr_q),
    .sel_i     (bus.byp_sel1),
    .hit_o     (bus.byp_hit1),
    .dat_o     (bus.byp_dat1)
  );

  wbq_bypass_match #(.DEPTH(DEPTH)) u_byp2 (
    .entries_i (entries_q),
    .rd_ptr_i  (rd_ptr_q),
    .sel_i     (bus.byp_sel2),
    .hit_o     (bus.byp_hit2),
    .dat_o     (bus.byp_dat2)
  );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for the writeback queue: reset, drain latency, arbitration,
// full stall, bypass, sel==0 drop and mid-operation reset.
module tb_regfile_writeback_queue;
  import regfile_writeback_queue_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  regfile_writeback_queue_if #(.DEPTH(4)) bus ();

  regfile_writeback_queue #(.DEPTH(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_sel = '0; bus.alu_dat = '0;
    bus.mem_valid = 1'b0; bus.mem_sel = '0; bus.mem_dat = '0;
    bus.wb_en = 1'b0; bus.byp_sel1 = '0; bus.byp_sel2 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    #1;
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.rf_WEN !== 1'b0) begin n_err++; $display("FAIL reset_wen got %b want 0", bus.rf_WEN); end
    n_cmp++; if (bus.rf_wsel !== 5'd0 || bus.rf_wdat !== 32'd0) begin n_err++; $display("FAIL reset_wport got %0d/%h want 0/0", bus.rf_wsel, bus.rf_wdat); end
    n_cmp++; if (bus.byp_hit1 !== 1'b0 || bus.byp_hit2 !== 1'b0 || bus.byp_dat1 !== 32'd0 || bus.byp_dat2 !== 32'd0) begin n_err++; $display("FAIL reset_byp got %b%b want 00", bus.byp_hit1, bus.byp_hit2); end
    n_cmp++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b%b want 11", bus.alu_ready, bus.mem_ready); end
  endtask

  task automatic test_single();
    bus.wb_en = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_sel = 5'd3; bus.alu_dat = 32'hDEADBEEF;
    #1;
    n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %b want 1", bus.alu_ready); end
    n_cmp++; if (bus.rf_WEN !== 1'b0) begin n_err++; $display("FAIL single_no_passthru got %b want 0", bus.rf_WEN); end
    tick();
    bus.alu_valid = 1'b0; bus.byp_sel1 = 5'd3;
    #1;
    n_cmp++; if (bus.rf_WEN !== 1'b1 || bus.rf_wsel !== 5'd3 || bus.rf_wdat !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_write got %b/%0d/%h want 1/3/deadbeef", bus.rf_WEN, bus.rf_wsel, bus.rf_wdat); end
    n_cmp++; if (bus.byp_hit1 !== 1'b1 || bus.byp_dat1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_head_bypass got %b/%h want 1/deadbeef", bus.byp_hit1, bus.byp_dat1); end
    tick();
    n_cmp++; if (bus.count !== 3'd0 || bus.rf_WEN !== 1'b0) begin n_err++; $display("FAIL single_drained got %0d/%b want 0/0", bus.count, bus.rf_WEN); end
    bus.byp_sel1 = '0;
  endtask

  task automatic test_priority();
    bus.wb_en = 1'b1;
    bus.mem_valid = 1'b1; bus.mem_sel = 5'd4; bus.mem_dat = 32'h11;
    bus.alu_valid = 1'b1; bus.alu_sel = 5'd7; bus.alu_dat = 32'h77;
    #1;
    n_cmp++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL prio_ready got mem=%b alu=%b want 1/0", bus.mem_ready, bus.alu_ready); end
    tick();
    bus.mem_valid = 1'b0;
    #1;
    n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL prio_alu_next got %b want 1", bus.alu_ready); end
    n_cmp++; if (bus.rf_WEN !== 1'b1 || bus.rf_wsel !== 5'd4 || bus.rf_wdat !== 32'h11) begin n_err++; $display("FAIL prio_first got %b/%0d/%h want 1/4/11", bus.rf_WEN, bus.rf_wsel, bus.rf_wdat); end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    n_cmp++; if (bus.rf_WEN !== 1'b1 || bus.rf_wsel !== 5'd7 || bus.rf_wdat !== 32'h77 || bus.count !== 3'd1) begin n_err++; $display("FAIL prio_second got %b/%0d/%h cnt %0d want 1/7/77 cnt 1", bus.rf_WEN, bus.rf_wsel, bus.rf_wdat, bus.count); end
    tick();
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL prio_drained got %0d want 0", bus.count); end
  endtask

  task automatic test_full();
    bus.wb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_sel = 5'(8 + i); bus.alu_dat = 32'h100 + 32'(i);
      #1;
      n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL full_fill_ready[%0d] got %b want 1", i, bus.alu_ready); end
      tick();
    end
    bus.alu_sel = 5'd12; bus.alu_dat = 32'h555;
    #1;
    n_cmp++; if (bus.count !== 3'd4 || bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0 || bus.rf_WEN !== 1'b0) begin n_err++; $display("FAIL full_state got cnt %0d rdy %b%b wen %b want 4 00 0", bus.count, bus.alu_ready, bus.mem_ready, bus.rf_WEN); end
    tick(); tick();
    n_cmp++; if (bus.count !== 3'd4 || bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL full_stall got cnt %0d rdy %b want 4 0", bus.count, bus.alu_ready); end
    bus.alu_valid = 1'b0;
    bus.wb_en = 1'b1;
    bus.mem_valid = 1'b1; bus.mem_sel = 5'd13; bus.mem_dat = 32'h999;
    #1;
    n_cmp++; if (bus.mem_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_no_free got %b want 0", bus.mem_ready); end
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (bus.rf_WEN !== 1'b1 || bus.rf_wsel !== 5'(8 + i) || bus.rf_wdat !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL full_drain[%0d] got %b/%0d/%h want 1/%0d/%h", i, bus.rf_WEN, bus.rf_wsel, bus.rf_wdat, 8 + i, 32'h100 + 32'(i)); end
      tick();
      bus.mem_valid = 1'b0;
    end
    n_cmp++; if (bus.count !== 3'd0 || bus.rf_WEN !== 1'b0) begin n_err++; $display("FAIL full_empty got %0d/%b want 0/0", bus.count, bus.rf_WEN); end
  endtask

  task automatic test_bypass();
    bus.wb_en = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_sel = 5'd5; bus.alu_dat = 32'd1;
    tick();
    bus.alu_dat = 32'd2;
    tick();
    bus.alu_sel = 5'd6; bus.alu_dat = 32'd9;
    bus.byp_sel1 = 5'd5; bus.byp_sel2 = 5'd0;
    #1;
    n_cmp++; if (bus.byp_hit1 !== 1'b1 || bus.byp_dat1 !== 32'd2) begin n_err++; $display("FAIL byp_youngest got %b/%0d want 1/2", bus.byp_hit1, bus.byp_dat1); end
    n_cmp++; if (bus.byp_hit2 !== 1'b0 || bus.byp_dat2 !== 32'd0) begin n_err++; $display("FAIL byp_sel_zero got %b/%0d want 0/0", bus.byp_hit2, bus.byp_dat2); end
    bus.byp_sel2 = 5'd6;
    #1;
    n_cmp++; if (bus.byp_hit2 !== 1'b0) begin n_err++; $display("FAIL byp_pending_req got %b want 0", bus.byp_hit2); end
    bus.alu_valid = 1'b0;
    bus.wb_en = 1'b1;
    tick();
    n_cmp++; if (bus.byp_hit1 !== 1'b1 || bus.byp_dat1 !== 32'd2 || bus.count !== 3'd1) begin n_err++; $display("FAIL byp_after_pop got %b/%0d cnt %0d want 1/2 cnt 1", bus.byp_hit1, bus.byp_dat1, bus.count); end
    tick();
    n_cmp++; if (bus.byp_hit1 !== 1'b0 || bus.count !== 3'd0) begin n_err++; $display("FAIL byp_empty got %b cnt %0d want 0 cnt 0", bus.byp_hit1, bus.count); end
    bus.byp_sel1 = '0; bus.byp_sel2 = '0;
  endtask

  task automatic test_sel_zero();
    bus.wb_en = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_sel = 5'd0; bus.alu_dat = 32'h55;
    #1;
    n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL sel0_ready got %b want 1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    n_cmp++; if (bus.count !== 3'd0 || bus.rf_WEN !== 1'b0) begin n_err++; $display("FAIL sel0_dropped got %0d/%b want 0/0", bus.count, bus.rf_WEN); end
    tick();
    n_cmp++; if (bus.rf_WEN !== 1'b0) begin n_err++; $display("FAIL sel0_no_write got %b want 0", bus.rf_WEN); end
  endtask

  task automatic test_reset_mid();
    bus.wb_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_sel = 5'(i); bus.alu_dat = 32'(i * 16);
      tick();
    end
    bus.alu_valid = 1'b0;
    #1;
    n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL rmid_fill got %0d want 3", bus.count); end
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    bus.wb_en = 1'b1; bus.byp_sel1 = 5'd1; bus.byp_sel2 = 5'd3;
    #1;
    n_cmp++; if (bus.count !== 3'd0 || bus.rf_WEN !== 1'b0) begin n_err++; $display("FAIL rmid_cleared got %0d/%b want 0/0", bus.count, bus.rf_WEN); end
    n_cmp++; if (bus.byp_hit1 !== 1'b0 || bus.byp_hit2 !== 1'b0) begin n_err++; $display("FAIL rmid_byp got %b%b want 00", bus.byp_hit1, bus.byp_hit2); end
    bus.alu_valid = 1'b1; bus.alu_sel = 5'd9; bus.alu_dat = 32'hABC;
    tick();
    bus.alu_valid = 1'b0;
    #1;
    n_cmp++; if (bus.rf_WEN !== 1'b1 || bus.rf_wsel !== 5'd9 || bus.rf_wdat !== 32'hABC) begin n_err++; $display("FAIL rmid_repush got %b/%0d/%h want 1/9/abc", bus.rf_WEN, bus.rf_wsel, bus.rf_wdat); end
    tick();
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL rmid_drained got %0d want 0", bus.count); end
    bus.byp_sel1 = '0; bus.byp_sel2 = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_full();
    test_bypass();
    test_sel_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
